// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle for the immediate stage.
// master drives the instruction side and consumer ready; slave is the stage.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate extraction stage, XLEN 32/64.
// Define RVC_IMM_EN to also decode compressed-instruction immediates.
module imm_gen_pipe #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_SH   = 3'd6;

  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        sh_f3;

  assign i     = bus.in_inst;
  assign op    = i[6:0];
  assign f3    = i[14:12];
  assign sh_f3 = (f3 == 3'b001) || (f3 == 3'b101);

  logic op_load, op_imm, op_imm32, op_store, op_branch;
  logic op_jalr, op_jal, op_lui, op_auipc, op_none;

  assign op_load   = (op == 7'h03);
  assign op_imm    = (op == 7'h13);
  assign op_imm32  = (op == 7'h1B);
  assign op_store  = (op == 7'h23);
  assign op_branch = (op == 7'h63);
  assign op_jalr   = (op == 7'h67);
  assign op_jal    = (op == 7'h6F);
  assign op_lui    = (op == 7'h37);
  assign op_auipc  = (op == 7'h17);
  assign op_none   = (op == 7'h33) || (op == 7'h73) || (op == 7'h0F);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-11){i[31]}}, i[30:20]};
  assign imm_s = {{(XLEN-11){i[31]}}, i[30:25], i[11:7]};
  assign imm_b = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){i[31]}}, i[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};

`ifdef RVC_IMM_EN
  logic [15:0]     c;
  logic            cq0, cq1, c_nz;
  logic [2:0]      cf3;
  logic [XLEN-1:0] c_ci, c_16sp, c_lui, c_j, c_b, c_lw;

  assign c    = i[15:0];
  assign cq0  = (c[1:0] == 2'b00);
  assign cq1  = (c[1:0] == 2'b01);
  assign cf3  = c[15:13];
  assign c_nz = |{c[12], c[6:2]};

  assign c_ci   = {{(XLEN-5){c[12]}}, c[6:2]};
  assign c_16sp = {{(XLEN-9){c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  assign c_lui  = {{(XLEN-17){c[12]}}, c[6:2], 12'b0};
  assign c_j    = {{(XLEN-11){c[12]}}, c[8], c[10:9], c[6], c[7],
                   c[2], c[11], c[5:3], 1'b0};
  assign c_b    = {{(XLEN-8){c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign c_lw   = {{(XLEN-7){1'b0}}, c[5], c[12:10], c[6], 2'b0};
`endif

  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_type;
  logic            d_ill;

  always_comb begin
    d_imm  = '0;
    d_type = T_NONE;
    d_ill  = 1'b0;
    if (i[1:0] != 2'b11) begin
`ifdef RVC_IMM_EN
      // compressed forms report the type of their 32-bit expansion
      unique case (1'b1)
        cq0 && cf3 == 3'b010: begin d_type = T_I; d_imm = c_lw; end
        cq0 && cf3 == 3'b110: begin d_type = T_S; d_imm = c_lw; end
        cq1 && (cf3 == 3'b000 || cf3 == 3'b010): begin
          d_type = T_I;
          d_imm  = c_ci;
        end
        cq1 && cf3 == 3'b011 && c[11:7] == 5'd2: begin
          d_type = T_I;
          d_imm  = c_16sp;
          d_ill  = !c_nz;
        end
        cq1 && cf3 == 3'b011 && c[11:7] != 5'd2: begin
          d_type = T_U;
          d_imm  = c_lui;
          d_ill  = !c_nz;
        end
        cq1 && cf3 == 3'b101: begin d_type = T_J; d_imm = c_j; end
        cq1 && cf3[2:1] == 2'b11: begin d_type = T_B; d_imm = c_b; end
        default: d_ill = 1'b1;
      endcase
`else
      d_ill = 1'b1;
`endif
    end else begin
      unique case (1'b1)
        op_load, op_jalr: begin d_type = T_I; d_imm = imm_i; end
        op_imm: begin
          if (sh_f3) begin
            d_type = T_SH;
            d_imm  = RV64 ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
            d_ill  = !RV64 && i[25];
          end else begin
            d_type = T_I;
            d_imm  = imm_i;
          end
        end
        op_imm32: begin
          if (!RV64) begin
            d_ill = 1'b1;
          end else if (sh_f3) begin
            d_type = T_SH;
            d_imm  = XLEN'(i[24:20]);
          end else begin
            d_type = T_I;
            d_imm  = imm_i;
          end
        end
        op_store:         begin d_type = T_S; d_imm = imm_s; end
        op_branch:        begin d_type = T_B; d_imm = imm_b; end
        op_jal:           begin d_type = T_J; d_imm = imm_j; end
        op_lui, op_auipc: begin d_type = T_U; d_imm = imm_u; end
        op_none:          d_ill = 1'b0;
        default:          d_ill = 1'b1;
      endcase
    end
  end

  logic            vld_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      type_q;
  logic            ill_q;
  logic            rdy;
  logic            take;

  // flush blocks acceptance so a redirected beat never lands
  assign rdy  = !bus.flush && (!vld_q || bus.out_ready);
  assign take = bus.in_valid && rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      imm_q  <= '0;
      type_q <= T_NONE;
      ill_q  <= 1'b0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (take) begin
      vld_q  <= 1'b1;
      imm_q  <= d_imm;
      type_q <= d_type;
      ill_q  <= d_ill;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = vld_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_type    = type_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe
// at XLEN=64 and XLEN=32 against a behavioural immediate model.
module tb_imm_gen_pipe;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  imm_gen_pipe_if #(.XLEN(64)) ia ();
  imm_gen_pipe_if #(.XLEN(32)) ib ();

  imm_gen_pipe #(.XLEN(64)) u64 (.clk(clk), .rst(rst), .bus(ia));
  imm_gen_pipe #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sx(input longint v, input int b);
    return (v <<< (64 - b)) >>> (64 - b);
  endfunction

  // returns {illegal, type, imm64}; imm is truncated for xlen 32
  function automatic logic [67:0] model(input logic [31:0] i, input int xlen);
    longint     v;
    logic [2:0] ty;
    logic       il;
    logic [2:0] f3;
    logic [63:0] r;
    v  = 0;
    ty = 3'd0;
    il = 1'b0;
    f3 = i[14:12];
    if (i[1:0] != 2'b11) begin
`ifdef RVC_IMM_EN
      logic [15:0] c;
      c = i[15:0];
      case ({c[1:0], c[15:13]})
        5'b00_010: begin ty = 3'd1; v = longint'({c[5], c[12:10], c[6], 2'b0}); end
        5'b00_110: begin ty = 3'd2; v = longint'({c[5], c[12:10], c[6], 2'b0}); end
        5'b01_000, 5'b01_010: begin ty = 3'd1; v = sx(longint'({c[12], c[6:2]}), 6); end
        5'b01_011: begin
          if (c[11:7] == 5'd2) begin
            ty = 3'd1;
            v  = sx(longint'({c[12], c[4:3], c[5], c[2], c[6], 4'b0}), 10);
          end else begin
            ty = 3'd4;
            v  = sx(longint'({c[12], c[6:2], 12'b0}), 18);
          end
          il = (v == 0);
        end
        5'b01_101: begin
          ty = 3'd5;
          v  = sx(longint'({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0}), 12);
        end
        5'b01_110, 5'b01_111: begin
          ty = 3'd3;
          v  = sx(longint'({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}), 9);
        end
        default: il = 1'b1;
      endcase
`else
      il = 1'b1;
`endif
    end else begin
      case (i[6:0])
        7'h03, 7'h67: begin ty = 3'd1; v = sx(longint'(i[31:20]), 12); end
        7'h13: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            ty = 3'd6;
            v  = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
            il = (xlen == 32) && i[25];
          end else begin
            ty = 3'd1;
            v  = sx(longint'(i[31:20]), 12);
          end
        end
        7'h1B: begin
          if (xlen == 32) il = 1'b1;
          else if (f3 == 3'b001 || f3 == 3'b101) begin ty = 3'd6; v = longint'(i[24:20]); end
          else begin ty = 3'd1; v = sx(longint'(i[31:20]), 12); end
        end
        7'h23: begin ty = 3'd2; v = sx(longint'({i[31:25], i[11:7]}), 12); end
        7'h63: begin
          ty = 3'd3;
          v  = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
        end
        7'h6F: begin
          ty = 3'd5;
          v  = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
        end
        7'h37, 7'h17: begin ty = 3'd4; v = sx(longint'({i[31:12], 12'b0}), 32); end
        7'h33, 7'h73, 7'h0F: il = 1'b0;
        default: il = 1'b1;
      endcase
    end
    r = 64'(v);
    if (xlen == 32) r = {32'b0, r[31:0]};
    return {il, ty, r};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[6:0] = 7'h03;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h17;
      3: r[6:0] = 7'h1B;  4: r[6:0] = 7'h23;  5: r[6:0] = 7'h33;
      6: r[6:0] = 7'h37;  7: r[6:0] = 7'h63;  8: r[6:0] = 7'h67;
      9: r[6:0] = 7'h6F;  10: r[6:0] = 7'h73; 11: r[6:0] = 7'h13;
      12, 13: r[1:0] = 2'($urandom_range(0, 2));
      default: ;
    endcase
    return r;
  endfunction

  task automatic idle();
    ia.in_valid = 1'b0; ia.in_inst = '0; ia.flush = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_inst = '0; ib.flush = 1'b0; ib.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic beat(input logic [31:0] inst);
    @(negedge clk);
    ia.in_valid = 1'b1; ia.in_inst = inst; ia.out_ready = 1'b1;
    ib.in_valid = 1'b1; ib.in_inst = inst; ib.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_imm !== 64'd0 || ia.out_type !== 3'd0 ||
        ia.out_illegal !== 1'b0 || ia.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset64 v=%b imm=%h t=%0d il=%b rdy=%b, want 0/0/0/0/1",
               ia.out_valid, ia.out_imm, ia.out_type, ia.out_illegal, ia.in_ready);
    end
    checks++;
    if (ib.out_valid !== 1'b0 || ib.out_imm !== 32'd0 || ib.out_type !== 3'd0) begin
      errors++;
      $display("FAIL reset32 v=%b imm=%h t=%0d, want 0/0/0",
               ib.out_valid, ib.out_imm, ib.out_type);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_formats();
    logic [63:0] e_imm;
    logic [2:0]  e_ty;
    logic        e_il;
    beat(32'hFFF00093);
    checks++;
    if (ib.out_valid !== 1'b1 || ib.out_imm !== 32'hFFFFFFFF ||
        ib.out_type !== 3'd1 || ib.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi32 v=%b imm=%h t=%0d il=%b, want 1/ffffffff/1/0",
               ib.out_valid, ib.out_imm, ib.out_type, ib.out_illegal);
    end
    checks++;
    if (ia.out_imm !== 64'hFFFFFFFFFFFFFFFF || ia.out_type !== 3'd1) begin
      errors++;
      $display("FAIL addi64 imm=%h t=%0d, want ffffffffffffffff/1", ia.out_imm, ia.out_type);
    end
    beat(32'h03F09093);
    checks++;
    if (ia.out_imm !== 64'd63 || ia.out_type !== 3'd6 || ia.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL slli64 imm=%h t=%0d il=%b, want 3f/6/0",
               ia.out_imm, ia.out_type, ia.out_illegal);
    end
    checks++;
    if (ib.out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL slli32 il=%b, want 1", ib.out_illegal);
    end
    beat(32'h800000B7);
    checks++;
    if (ia.out_imm !== 64'hFFFFFFFF80000000 || ia.out_type !== 3'd4) begin
      errors++;
      $display("FAIL lui64 imm=%h t=%0d, want ffffffff80000000/4", ia.out_imm, ia.out_type);
    end
    beat(32'hFE000EE3);
    checks++;
    if (ia.out_imm !== 64'hFFFFFFFFFFFFFFFC || ia.out_type !== 3'd3 ||
        ib.out_imm !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL beq imm64=%h imm32=%h t=%0d, want fffffffffffffffc/fffffffc/3",
               ia.out_imm, ib.out_imm, ia.out_type);
    end
    beat(32'h0010809B);
    checks++;
    if (ia.out_imm !== 64'd1 || ia.out_type !== 3'd1 || ib.out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL addiw imm64=%h t=%0d il32=%b, want 1/1/1",
               ia.out_imm, ia.out_type, ib.out_illegal);
    end
    beat(32'h002081B3);
    checks++;
    if (ia.out_type !== 3'd0 || ia.out_imm !== 64'd0 || ia.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_none t=%0d imm=%h il=%b, want 0/0/0",
               ia.out_type, ia.out_imm, ia.out_illegal);
    end
    beat(32'h0000007F);
    checks++;
    if (ia.out_type !== 3'd0 || ia.out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL bad_op t=%0d il=%b, want 0/1", ia.out_type, ia.out_illegal);
    end
`ifdef RVC_IMM_EN
    e_imm = 64'd1; e_ty = 3'd1; e_il = 1'b0;
`else
    e_imm = 64'd0; e_ty = 3'd0; e_il = 1'b1;
`endif
    beat(32'h00004505);
    checks++;
    if (ia.out_imm !== e_imm || ia.out_type !== e_ty || ia.out_illegal !== e_il) begin
      errors++;
      $display("FAIL c_li imm=%h t=%0d il=%b, want %h/%0d/%b",
               ia.out_imm, ia.out_type, ia.out_illegal, e_imm, e_ty, e_il);
    end
  endtask

  task automatic test_stall();
    logic [31:0] list [4];
    logic [63:0] held;
    logic [67:0] e;
    int sent, recv, last;
    list[0] = 32'h00500093;
    list[1] = 32'h123450B7;
    list[2] = 32'hFE000EE3;
    list[3] = 32'h0080006F;
    sent = 0; recv = 0; last = -1; held = '0;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      ia.out_ready = !(cyc >= 2 && cyc <= 4);
      ia.in_valid  = (sent < 4);
      ia.in_inst   = (sent < 4) ? list[sent] : 32'd0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (ia.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready cyc=%0d rdy=%b, want 0", cyc, ia.in_ready);
        end
        if (cyc == 2) held = ia.out_imm;
        else begin
          checks++;
          if (ia.out_imm !== held) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d imm=%h, want %h", cyc, ia.out_imm, held);
          end
        end
      end
      if (ia.out_valid && ia.out_ready && recv < 4) begin
        e = model(list[recv], 64);
        checks++;
        if (ia.out_imm !== e[63:0] || ia.out_type !== e[66:64]) begin
          errors++;
          $display("FAIL stall_data n=%0d imm=%h t=%0d, want %h/%0d",
                   recv, ia.out_imm, ia.out_type, e[63:0], e[66:64]);
        end
        recv++;
        last = cyc;
      end
      if (ia.in_valid && ia.in_ready) sent++;
    end
    checks++;
    if (recv != 4 || last != 7) begin
      errors++;
      $display("FAIL stall_count recv=%0d last=%0d, want 4/7", recv, last);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    beat(32'h00500093);
    @(negedge clk);
    ia.flush = 1'b1; ia.in_valid = 1'b1; ia.in_inst = 32'h800000B7; ia.out_ready = 1'b0;
    #1;
    checks++;
    if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready v=%b rdy=%b, want 1/0", ia.out_valid, ia.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ia.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill v=%b, want 0", ia.out_valid);
    end
    @(negedge clk);
    ia.flush = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ia.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop v=%b, want 0", ia.out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    beat(32'h800000B7);
    @(negedge clk);
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    #1;
    checks++;
    if (ia.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre v=%b, want 1", ia.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_imm !== 64'd0 || ia.out_type !== 3'd0 ||
        ia.out_illegal !== 1'b0 || ib.out_valid !== 1'b0 || ib.out_imm !== 32'd0) begin
      errors++;
      $display("FAIL arst v=%b imm=%h t=%0d il=%b v32=%b, want all 0",
               ia.out_valid, ia.out_imm, ia.out_type, ia.out_illegal, ib.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_random(input int n);
    logic [67:0] q64 [$];
    logic [67:0] q32 [$];
    logic [67:0] e;
    logic [31:0] inst;
    logic        iv, ordy, fl, er;
    do_reset();
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      inst = rand_inst();
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0) && !ordy;
      ia.in_inst = inst; ia.in_valid = iv; ia.out_ready = ordy; ia.flush = fl;
      ib.in_inst = inst; ib.in_valid = iv; ib.out_ready = ordy; ib.flush = fl;
      #1;
      er = !fl && (q64.size() == 0 || ordy);
      checks++;
      if (ia.in_ready !== er || ia.out_valid !== (q64.size() != 0) ||
          ib.in_ready !== er || ib.out_valid !== (q32.size() != 0)) begin
        errors++;
        $display("FAIL rand_hs cyc=%0d rdy=%b/%b v=%b/%b, want rdy=%b v=%b/%b", cyc,
                 ia.in_ready, ib.in_ready, ia.out_valid, ib.out_valid, er,
                 q64.size() != 0, q32.size() != 0);
      end
      if (q64.size() != 0 && ordy) begin
        e = q64.pop_front();
        checks++;
        if (ia.out_imm !== e[63:0] || ia.out_type !== e[66:64] || ia.out_illegal !== e[67]) begin
          errors++;
          $display("FAIL rand64 cyc=%0d imm=%h t=%0d il=%b, want %h/%0d/%b", cyc,
                   ia.out_imm, ia.out_type, ia.out_illegal, e[63:0], e[66:64], e[67]);
        end
      end
      if (q32.size() != 0 && ordy) begin
        e = q32.pop_front();
        checks++;
        if (ib.out_imm !== e[31:0] || ib.out_type !== e[66:64] || ib.out_illegal !== e[67]) begin
          errors++;
          $display("FAIL rand32 cyc=%0d imm=%h t=%0d il=%b, want %h/%0d/%b", cyc,
                   ib.out_imm, ib.out_type, ib.out_illegal, e[31:0], e[66:64], e[67]);
        end
      end
      if (fl) begin
        q64.delete();
        q32.delete();
      end else if (iv && er) begin
        q64.push_back(model(inst, 64));
        q32.push_back(model(inst, 32));
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_formats();
    test_stall();
    test_flush();
    test_async_reset();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
